// File: rtl/s1_xfer.sv
// s1_xfer: S1 end of the RB1/RB2 serial transpose link.
// Sends RB1 as 8 bit-plane frames on sd, then writes back 18 returned rows.
module s1_xfer (
  input  logic       clk,
  input  logic       rst,
  input  logic       updown,
  output logic       S1_done,
  output logic       RB1_RW,
  output logic [4:0] RB1_A,
  output logic [7:0] RB1_D,
  input  logic [7:0] RB1_Q,
  inout  wire        sen,
  inout  wire        sd
);

  typedef enum logic [1:0] {
    SEND = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_frame;
  logic [4:0]  r_pos;
  logic [4:0]  r_slot;
  logic [12:0] r_shift;
  logic        r_sd;
  logic        w_drv;
  logic        w_bit;
  logic [2:0]  w_nf;

  assign w_nf = r_frame + 3'd1;
  assign sen  = 1'bz;
  assign sd   = w_drv ? r_sd : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= SEND;
    else     r_state <= w_next;
  end

  // pos 22 is the turnaround edge E177; pos 14 is the post-write edge
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      SEND:    if (r_pos == 5'd22) w_next = RECV;
      RECV:    if (r_pos == 5'd14) w_next = DONE;
      default: w_next = DONE;
    endcase
  end

  always_comb begin
    S1_done = (r_state == DONE);
    w_drv   = (r_state == SEND) && (r_pos != 5'd22) && !updown;
    w_bit   = 1'b0;
    if (r_pos == 5'd0)
      w_bit = r_frame[1];
    else if (r_pos == 5'd1)
      w_bit = r_frame[0];
    else if (r_pos >= 5'd2 && r_pos <= 5'd19)
      w_bit = RB1_Q[r_frame];
    else if (r_pos == 5'd21)
      w_bit = w_nf[2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame <= 3'd0;
      r_pos   <= 5'd0;
      r_slot  <= 5'd0;
      r_shift <= 13'd0;
      r_sd    <= 1'b0;
      RB1_RW  <= 1'b1;
      RB1_A   <= 5'd0;
      RB1_D   <= 8'd0;
    end else begin
      unique case (r_state)
        SEND: begin
          r_sd <= w_bit;
          // row r is addressed one edge before its bit is loaded
          if (r_pos >= 5'd1 && r_pos <= 5'd18)
            RB1_A <= r_pos - 5'd1;
          else
            RB1_A <= 5'd0;
          if (r_pos == 5'd22) begin
            r_pos <= 5'd0;
          end else if (r_pos == 5'd21) begin
            if (r_frame == 3'd7) begin
              r_pos <= 5'd22;
            end else begin
              r_pos   <= 5'd0;
              r_frame <= w_nf;
            end
          end else begin
            r_pos <= r_pos + 5'd1;
          end
        end
        RECV: begin
          RB1_RW <= 1'b1;
          if (r_pos == 5'd13) begin
            if (r_shift[12:8] < 5'd18) begin
              RB1_A  <= r_shift[12:8];
              RB1_D  <= r_shift[7:0];
              RB1_RW <= 1'b0;
            end
            if (r_slot == 5'd17) begin
              r_pos <= 5'd14;
            end else begin
              r_pos  <= 5'd0;
              r_slot <= r_slot + 5'd1;
            end
          end else if (r_pos <= 5'd12) begin
            r_shift <= {r_shift[11:0], sd};
            r_pos   <= r_pos + 5'd1;
          end
        end
        default: RB1_RW <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_s1_xfer.sv
// tb_s1_xfer: directed bench with RB1 memory model and an S2 loopback model.
// Covers send schedule, loopback write-back, bad index, resets and hi-Z.
module tb_s1_xfer;

  logic       clk = 1'b0;
  logic       rst, updown, tb_en, tb_bit, clr, clob;
  wire        sen, sd;
  logic       S1_done, RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_D, RB1_Q;

  logic [7:0] rb1 [18];
  logic [7:0] init_img [18];
  logic       cap [0:440];
  logic [4:0] wr_log [32];
  int         wr_n, rw0_n, total, bad;

  typedef struct {
    int          first;
    int          len;
    logic [31:0] bits;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  assign sd = tb_en ? tb_bit : 1'bz;

  s1_xfer dut (
    .clk(clk), .rst(rst), .updown(updown),
    .S1_done(S1_done), .RB1_RW(RB1_RW),
    .RB1_A(RB1_A), .RB1_D(RB1_D), .RB1_Q(RB1_Q),
    .sen(sen), .sd(sd)
  );

  always_comb RB1_Q = (RB1_A < 5'd18) ? rb1[RB1_A] : 8'h00;

  always @(posedge clk) begin
    if (clr) begin
      wr_n <= 0;
      for (int i = 0; i < 18; i++) rb1[i] <= init_img[i];
    end else if (clob) begin
      for (int i = 0; i < 18; i++) rb1[i] <= 8'h00;
    end else if (!rst && !RB1_RW) begin
      if (RB1_A < 5'd18) rb1[RB1_A] <= RB1_D;
      if (wr_n < 32) wr_log[wr_n] <= RB1_A;
      wr_n <= wr_n + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic exp_bit(input int n);
    int f, p;
    logic [2:0] fa;
    f  = (n - 1) / 22;
    p  = (n - 1) % 22;
    fa = f[2:0];
    if (p < 3) return fa[2 - p];
    if (p <= 20) return init_img[p - 3][f];
    return 1'b0;
  endfunction

  task automatic rst_chk(input string pre);
    chk({pre, "_done"}, 32'(S1_done), 32'd0);
    chk({pre, "_rw"}, 32'(RB1_RW), 32'd1);
    chk({pre, "_a"}, 32'(RB1_A), 32'd0);
    chk({pre, "_d"}, 32'(RB1_D), 32'd0);
    chk({pre, "_sd"}, 32'(sd), 32'd0);
  endtask

  task automatic run(input int ud_hi, input int inj, input int abort_n);
    logic [12:0] w;
    logic [7:0]  b;
    int s, k;
    rst = 1'b1; clr = 1'b1; clob = 1'b0;
    updown = 1'b0; tb_en = 1'b0; tb_bit = 1'b0;
    rw0_n = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_chk("rst");
    @(negedge clk);
    clr = 1'b0;
    rst = 1'b0;
    for (int n = 1; n <= 440; n++) begin
      clob = (n == 177);
      if (n >= 178) begin
        updown = 1'b1;
        tb_en  = 1'b1;
        s = (n - 178) / 14;
        k = (n - 178) % 14;
        if (s < 18 && k <= 12) begin
          for (int f = 0; f < 8; f++) b[f] = cap[22 * f + 4 + s];
          w = (s == inj) ? {5'd20, 8'hA5} : {s[4:0], b};
          tb_bit = w[12 - k];
        end else begin
          tb_bit = 1'b1;
        end
      end else begin
        updown = (n <= ud_hi);
        tb_en  = (n <= ud_hi);
        tb_bit = 1'b0;
      end
      #1;
      if (n <= 176) cap[n] = sd;
      if (n <= ud_hi) chk("ud_hiz", 32'(sd), 32'd0);
      if (!RB1_RW) rw0_n++;
      if (abort_n == 0 && n == 430)
        chk("pre_done", 32'({RB1_RW, S1_done}), 32'd0);
      if (abort_n == 0 && n == 431)
        chk("done_set", 32'({RB1_RW, S1_done}), 32'd3);
      if (n == abort_n) begin
        updown = 1'b0;
        tb_en  = 1'b0;
        clob   = 1'b0;
        #2 rst = 1'b1;
        #1 rst_chk("abort");
        repeat (2) @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    chk("done_hold", 32'({RB1_RW, S1_done}), 32'd3);
  endtask

  task automatic chk_frames(input int f0);
    logic [31:0] a, e;
    for (int f = f0; f < 8; f++) begin
      a = 32'd0;
      e = 32'd0;
      for (int p = 0; p < 22; p++) begin
        a = {a[30:0], cap[22 * f + 1 + p]};
        e = {e[30:0], exp_bit(22 * f + 1 + p)};
      end
      chk($sformatf("frame%0d", f), a, e);
    end
  endtask

  task automatic chk_back(input int inj, input int nwr);
    int j;
    j = 0;
    chk("wr_count", 32'(wr_n), 32'(nwr));
    chk("rw0_cycles", 32'(rw0_n), 32'(nwr));
    for (int s = 0; s < 18; s++) begin
      if (s != inj) begin
        chk($sformatf("wr_idx%0d", j), 32'(wr_log[j]), 32'(s));
        j++;
      end
    end
    for (int r = 0; r < 18; r++)
      chk($sformatf("row%0d", r), 32'(rb1[r]),
          32'((r == inj) ? 8'h00 : init_img[r]));
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; clr = 1'b0; clob = 1'b0;
    updown = 1'b0; tb_en = 1'b0; tb_bit = 1'b0;
    tbl[0] = '{1,   21, 32'b000101010101010101010};
    tbl[1] = '{22,  1,  32'b0};
    tbl[2] = '{23,  21, 32'b001011001100110011001};
    tbl[3] = '{89,  21, 32'b100000000000000000111};
    tbl[4] = '{111, 21, 32'b101000000000000000000};
    tbl[5] = '{133, 3,  32'b110};
    tbl[6] = '{155, 3,  32'b111};
    tbl[7] = '{176, 1,  32'b0};

    for (int r = 0; r < 18; r++) init_img[r] = 8'(r + 1);
    run(0, -1, 0);
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a;
      a = 32'd0;
      for (int j = 0; j < tbl[i].len; j++)
        a = {a[30:0], cap[tbl[i].first + j]};
      chk($sformatf("vec%0d_E%0d", i, tbl[i].first), a, tbl[i].bits);
    end
    chk_frames(0);
    chk_back(-1, 18);

    for (int r = 0; r < 18; r++) init_img[r] = 8'((r * 29) ^ 8'h5A);
    run(0, 5, 0);
    chk_frames(0);
    chk_back(5, 17);

    run(0, -1, 100);
    chk("abort_send_wr", 32'(wr_n), 32'd0);
    run(0, -1, 0);
    chk("restart_E1_3", 32'({cap[1], cap[2], cap[3]}), 32'd0);
    chk_frames(0);
    chk_back(-1, 18);

    run(0, -1, 233);
    chk("abort_recv_wr", 32'(wr_n), 32'd3);

    run(44, -1, 177);
    chk_frames(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/s1_xfer.md
S1_XFER -- requirements
Module: s1_xfer

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: updown  in  1  link direction; 0 = s1_xfer drives sd, 1 = S2 drives sd.
REQ-004 SHALL have: S1_done  out  1  set when the round trip completes.
REQ-005 SHALL have: RB1_RW  out  1  register bank 1 control; 1 = read, 0 = write.
REQ-006 SHALL have: RB1_A  out  5  RB1 row address, 0..17.
REQ-007 SHALL have: RB1_D  out  8  RB1 write data.
REQ-008 SHALL have: RB1_Q  in  8  RB1 read data, combinational from RB1_A.
REQ-009 SHALL have: sen  inout  1  reserved; held at high-impedance.
REQ-010 SHALL have: sd  inout  1  serial link to S2, MSB first, one bit per clock.

Function
REQ-011 Edge numbering: E1 = first rising clk edge after rst deasserts; "bit for En" = the value sd holds between E(n-1) and En (from rst release for E1).
REQ-012 SHALL drive sd only when updown=0 and in SEND phase; otherwise sd = z.
REQ-013 SEND phase: 8 frames f=0..7, each 22 edges: bits for E(22f+1..22f+21), then one gap edge E(22f+22).
REQ-014 Frame f content: f[2:0] MSB first, then 18 data bits D[17..0] with D[17-r] = RB1 row r bit f, i.e. rows 0..17 in order.
REQ-015 Gap-edge bit SHALL be 0; S2 performs its write on that edge.
REQ-016 sd output SHALL be registered; reset value 0 (equals frame 0 first address bit).
REQ-017 Row r SHALL be addressed on RB1_A, with RB1_RW=1, by the edge before the sd register loads that row's bit.
REQ-018 SEND phase ends after E176; sd goes z from E176 onward.
REQ-019 RECV phase: 18 slots s=0..17, bits sampled at E(178+14s+k), k=0..12.
REQ-020 Slot bit layout: k=0..4 = index idx[4:0] MSB first; k=5..12 = byte[7..0] MSB first.
REQ-021 Edge E(191+14s) is S2's idle edge; sd SHALL be ignored there.
REQ-022 Write step: on the edge after the k=12 sample, SHALL present RB1_A=idx, RB1_D=byte, RB1_RW=0 for exactly one cycle, then RB1_RW=1.
REQ-023 Received idx is not checked against s; idx >= 18 SHALL suppress the write.
REQ-024 After slot 17's write cycle, SHALL set S1_done=1, enter DONE, and ignore sd.
REQ-025 S1_done SHALL stay 1 until rst; in DONE: RB1_RW=1 and sd=z.
REQ-026 States: SEND -> RECV (after E177; S2 drives first index bit from E177) -> DONE.
REQ-027 Counters: 3-bit frame count, 5-bit bit/row count, 5-bit slot count; no wrap beyond stated ranges.
REQ-028 Net result: RB1 is transposed through RB2 and returned, so final RB1 equals initial RB1.
REQ-029 updown is environment-driven; if updown=1 during SEND, the sd register SHALL still advance on schedule (bits lost, no stall).

Reset
REQ-030 On rst: S1_done=0, RB1_RW=1, RB1_A=0, RB1_D=0, sd register=0, state=SEND, all counters 0.
REQ-031 rst asserted mid-SEND or mid-RECV SHALL abort immediately with no further RB1 write, and the next release SHALL restart at frame 0.

Verification
REQ-032 RB1 row r = r+1, updown=0 through E176: sd bits at E1..E21 = 000 followed by bit0 of rows 0..17; E22 bit = 0.
REQ-033 Frame 5 check: bits for E111..E113 = 101; E114..E131 = bit5 of rows 0..17.
REQ-034 Loopback with S2 model, updown=1 from E177: RB1_RW=0 exactly 18 times, idx ascending 0..17; final RB1 equals initial; S1_done=1 after the 18th write.
REQ-035 Injected slot with idx=20, byte=8'hA5 -> no RB1 write in that slot, remaining slots unaffected.
REQ-036 rst pulse at E100 -> outputs return to reset values asynchronously; after release, sd bits for E1..E3 = 000 again and the full sequence completes.
REQ-037 updown=1 during SEND -> sd high-impedance from s1_xfer (no contention); with updown=0, sd never z before E176.
